// File: rtl/mult_control_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding,
// default operand width and accumulator width. Imported by the control unit,
// its step counter and any accumulator/top that needs the same encodings.
package mult_control_pkg;

    // 3-bit state encoding shared with the accumulator and multiplier top
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_ADDSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Default multiplier width (number of shift steps)
    localparam int N_DEFAULT = 4;

    // Accumulator width: N-bit product halves plus one carry bit
    localparam int ACC_W_DEFAULT = 2 * N_DEFAULT + 1;

    // Step counter width; at least one bit so N=1 still elaborates
    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Shift-step counter for the multiplier control unit. Cleared while the
// operands are loaded, incremented once per shift, and flags the final step
// (count == N-1). It wraps back to zero after the last step so it can never
// exceed N-1.
module mult_step_counter
    import mult_control_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(N - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             last_s;

    // Decode the final step from the current count
    always_comb begin
        last_s = 1'b0;
        if (count_r == LAST_VAL) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next count: clear has priority, increment wraps after the last step
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (inc) begin
            if (last_s) begin
                count_nxt_s = {CNT_W{1'b0}};
            end else begin
                count_nxt_s = count_r + CNT_W'(1);
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Step count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign last = last_s;

endmodule

// File: rtl/mult_control.sv
// Control unit for the shift-add multiplier. Drives the accumulator's
// Load/Sh/Ad inputs: one load, then N steps where the accumulator LSB (M)
// chooses add-then-shift or shift only. Busy covers LOAD through the last
// shift; Done pulses for one cycle when the product is valid.
// Load, Busy, Done and the ADDSH shift are registered. In EVAL, Ad/Sh are
// gated by M (Mealy) so the add lands in the same step that examines the bit.
// Optional feature macro: MULT_CTRL_CYCLE_CNT_EN adds the Cycles[7:0] output
// holding the number of LOAD+EVAL+ADDSH cycles of the last operation.
module mult_control
    import mult_control_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       St,
    input  logic       M,
    output logic       Load,
    output logic       Sh,
    output logic       Ad,
    output logic       Busy,
    output logic       Done
`ifdef MULT_CTRL_CYCLE_CNT_EN
    ,
    output logic [7:0] Cycles
`endif
);

    state_t state_r;
    logic   load_r;
    logic   busy_r;
    logic   done_r;
    logic   sh_r;
    logic   eval_r;

    logic   last_s;
    logic   cnt_clr_s;
    logic   cnt_inc_s;
    logic   to_done_s;

    // Step counter control: clear in LOAD, count every shift
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        to_done_s = 1'b0;
        case (state_r)
            ST_LOAD: begin
                cnt_clr_s = 1'b1;
            end
            ST_EVAL: begin
                cnt_inc_s = ~M;
                to_done_s = ~M & last_s;
            end
            ST_ADDSH: begin
                cnt_inc_s = 1'b1;
                to_done_s = last_s;
            end
            default: begin
                cnt_clr_s = 1'b0;
                cnt_inc_s = 1'b0;
                to_done_s = 1'b0;
            end
        endcase
    end

    mult_step_counter #(
        .N (N)
    ) u_step_counter (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .last  (last_s)
    );

    // Sequencing FSM with registered Moore outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sh_r    <= 1'b0;
            eval_r  <= 1'b0;
        end else begin
            load_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sh_r   <= 1'b0;
            eval_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (St) begin
                        state_r <= ST_LOAD;
                        load_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_EVAL;
                    busy_r  <= 1'b1;
                    eval_r  <= 1'b1;
                end
                ST_EVAL: begin
                    if (M) begin
                        state_r <= ST_ADDSH;
                        busy_r  <= 1'b1;
                        sh_r    <= 1'b1;
                    end else if (to_done_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_EVAL;
                        busy_r  <= 1'b1;
                        eval_r  <= 1'b1;
                    end
                end
                ST_ADDSH: begin
                    if (to_done_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_EVAL;
                        busy_r  <= 1'b1;
                        eval_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Load = load_r;
    assign Busy = busy_r;
    assign Done = done_r;
    // EVAL chooses between add (M=1) and shift (M=0); never both at once
    assign Ad   = eval_r & M;
    assign Sh   = sh_r | (eval_r & ~M);

`ifdef MULT_CTRL_CYCLE_CNT_EN
    logic [7:0] cyc_cnt_r;
    logic [7:0] cycles_r;

    // Count busy cycles and latch the total (including this one) on entry to DONE
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cyc_cnt_r <= 8'd0;
            cycles_r  <= 8'd0;
        end else begin
            if ((state_r == ST_LOAD) || (state_r == ST_EVAL) || (state_r == ST_ADDSH)) begin
                cyc_cnt_r <= cyc_cnt_r + 8'd1;
            end else begin
                cyc_cnt_r <= 8'd0;
            end
            if (to_done_s) begin
                cycles_r <= cyc_cnt_r + 8'd1;
            end else begin
                cycles_r <= cycles_r;
            end
        end
    end

    assign Cycles = cycles_r;
`endif

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control. A behavioural 9-bit accumulator is
// driven by the DUT's Load/Ad/Sh and feeds M back. Each started operation
// pushes its expected per-cycle {Load,Ad,Sh,Busy,Done} vectors, product and
// cycle count into queues; every cycle pops one vector and compares, and
// every Done pops and compares the product.
module tb_mult_control;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } op_t;

    logic       Clk;
    logic       Rst_n;
    logic       St;
    logic       M;
    logic       Load;
    logic       Sh;
    logic       Ad;
    logic       Busy;
    logic       Done;
`ifdef MULT_CTRL_CYCLE_CNT_EN
    logic [7:0] Cycles;
`endif

    logic [2*N:0] acc = '0;
    logic [N-1:0] cur_a = '0;

    op_t          op_q[$];
    logic [4:0]   exp_q[$];
    int           prod_q[$];
    int           cyc_q[$];

    int total = 0;
    int bad = 0;

    mult_control #(.N(N)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .St    (St),
        .M     (M),
        .Load  (Load),
        .Sh    (Sh),
        .Ad    (Ad),
        .Busy  (Busy),
        .Done  (Done)
`ifdef MULT_CTRL_CYCLE_CNT_EN
        ,
        .Cycles(Cycles)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Accumulator model: load {0, multiplier}, add multiplicand to the upper half, shift right
    always @(posedge Clk) begin
        if (Load) begin
            if (op_q.size() > 0) begin
                acc   <= {{(N+1){1'b0}}, op_q[0].b};
                cur_a <= op_q[0].a;
                op_q.pop_front();
            end
        end else if (Ad) begin
            acc[2*N:N] <= {1'b0, acc[2*N-1:N]} + {1'b0, cur_a};
        end else if (Sh) begin
            acc <= acc >> 1;
        end
    end

    assign M = acc[0];

    task automatic push_op(input logic [N-1:0] a, input logic [N-1:0] b);
        int pc;
        op_t o;
        o.a = a;
        o.b = b;
        op_q.push_back(o);
        prod_q.push_back(int'(a) * int'(b));
        pc = 0;
        exp_q.push_back(5'b10010);
        for (int i = 0; i < N; i++) begin
            if (b[i]) begin
                exp_q.push_back(5'b01010);
                exp_q.push_back(5'b00110);
                pc++;
            end else begin
                exp_q.push_back(5'b00110);
            end
        end
        exp_q.push_back(5'b00001);
        cyc_q.push_back(1 + N + pc);
    endtask

    task automatic check_cycle(input string tag);
        logic [4:0] e;
        logic [4:0] o;
        int p;
        @(negedge Clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
        o = {Load, Ad, Sh, Busy, Done};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL %s outputs{Load,Ad,Sh,Busy,Done} got=%b want=%b t=%0t", tag, o, e, $time);
        end
        if (Done === 1'b1 && prod_q.size() > 0) begin
            p = prod_q.pop_front();
            total++;
            if (acc !== (2*N+1)'(p)) begin
                bad++;
                $display("FAIL %s product got=%0d want=%0d", tag, acc, p);
            end
`ifdef MULT_CTRL_CYCLE_CNT_EN
            if (cyc_q.size() > 0) begin
                p = cyc_q.pop_front();
                total++;
                if (Cycles !== 8'(p)) begin
                    bad++;
                    $display("FAIL %s cycles got=%0d want=%0d", tag, Cycles, p);
                end
            end
`endif
        end
    endtask

    // Iteration k drives St=mask[k] (sampled at the next rising edge) and then checks that cycle
    task automatic run_cycles(input string tag, input int n, input logic [63:0] mask);
        for (int k = 0; k < n; k++) begin
            St = mask[k];
            check_cycle(tag);
        end
        St = 1'b0;
        total++;
        if (prod_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending got=%0d/%0d want=0/0", tag, prod_q.size(), exp_q.size());
        end
        prod_q.delete();
        exp_q.delete();
        cyc_q.delete();
        op_q.delete();
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        St    = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if ({Load, Ad, Sh, Busy, Done} !== 5'b00000) begin
            bad++;
            $display("FAIL reset outputs got=%b want=00000", {Load, Ad, Sh, Busy, Done});
        end
`ifdef MULT_CTRL_CYCLE_CNT_EN
        total++;
        if (Cycles !== 8'd0) begin
            bad++;
            $display("FAIL reset cycles got=%0d want=0", Cycles);
        end
`endif
        #2 Rst_n = 1'b1;
        run_cycles("reset_idle", 3, 64'd0);
    endtask

    task automatic test_mult(input logic [N-1:0] a, input logic [N-1:0] b);
        push_op(a, b);
        run_cycles($sformatf("mult_%0dx%0d", a, b), 2 + N + $countones(b) + 2, 64'd1);
    endtask

    task automatic test_st_ignored();
        // 9*5: Done at iteration 7; St again during busy (2,4) and while in DONE (8)
        push_op(4'd9, 4'd5);
        run_cycles("st_ignored", 12, 64'h0000_0000_0000_0115);
    endtask

    task automatic test_back_to_back();
        // 7*11 (9 vectors), one IDLE cycle, then 13*6; St held high until the second Load
        push_op(4'd7, 4'd11);
        exp_q.push_back(5'b00000);
        push_op(4'd13, 4'd6);
        run_cycles("back_to_back", 21, 64'h0000_0000_0000_07FF);
    endtask

    task automatic test_reset_mid_op();
        push_op(4'd7, 4'd11);
        St = 1'b1;
        check_cycle("rst_mid_load");
        St = 1'b0;
        check_cycle("rst_mid_eval");
        #2 Rst_n = 1'b0;
        #1;
        total++;
        if ({Load, Ad, Sh, Busy, Done} !== 5'b00000) begin
            bad++;
            $display("FAIL rst_mid_async outputs got=%b want=00000", {Load, Ad, Sh, Busy, Done});
        end
        prod_q.delete();
        exp_q.delete();
        cyc_q.delete();
        op_q.delete();
        @(posedge Clk);
        #2 Rst_n = 1'b1;
        run_cycles("rst_mid_idle", 4, 64'd0);
`ifdef MULT_CTRL_CYCLE_CNT_EN
        total++;
        if (Cycles !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_cycles got=%0d want=0", Cycles);
        end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            test_mult(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        St    = 1'b0;
        Rst_n = 1'b0;
        test_reset();
        test_mult(4'd7, 4'd11);
        test_mult(4'd15, 4'd0);
        test_mult(4'd15, 4'd15);
        test_st_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_mult(4'd7, 4'd11);
        test_mult(4'd3, 4'd0);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
